// File: rtl/fetch_unit_pkg.sv
// Shared fetch/memory definitions: access modes, memory map and fetch-state encoding.
// Also used by mainmem and its bench.
package fetch_unit_pkg;

  localparam logic READ  = 1'b0;
  localparam logic WRITE = 1'b1;

  localparam logic [31:0] STARTING_ADDR   = 32'h0100_0000;
  localparam logic [31:0] MEM_DEPTH_BYTES = 32'h0010_0000;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry in-order FIFO for fetched {pc, instruction} pairs.
// The head always lives in slot0, so the outputs come straight from registers.
module fetch_buffer #(
  parameter int WIDTH = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enq,
  input  logic             deq,
  input  logic             flush,
  input  logic [WIDTH-1:0] enq_data,
  output logic [WIDTH-1:0] head_data,
  output logic             head_valid,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] slot0;
  logic [WIDTH-1:0] slot1;
  logic             do_deq;
  logic             do_enq;

  assign do_deq = deq & (count != 2'd0);
  assign do_enq = enq & ((count < 2'd2) | do_deq);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      slot0 <= '0;
      slot1 <= '0;
      count <= 2'd0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      case ({do_enq, do_deq})
        2'b11: begin
          // Dequeue and enqueue together: the count is unchanged.
          if (count == 2'd2) begin
            slot0 <= slot1;
            slot1 <= enq_data;
          end else begin
            slot0 <= enq_data;
          end
        end
        2'b01: begin
          slot0 <= slot1;
          count <= count - 2'd1;
        end
        2'b10: begin
          if (count == 2'd0) slot0 <= enq_data;
          else               slot1 <= enq_data;
          count <= count + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign head_data  = slot0;
  assign head_valid = (count != 2'd0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: reads mainmem at pc, buffers {pc, word} pairs for decode,
// and handles redirects. An unfetchable pc parks the unit in FAULT until reset.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] STARTING_ADDR   = fetch_unit_pkg::STARTING_ADDR,
  parameter logic [31:0] MEM_DEPTH_BYTES = fetch_unit_pkg::MEM_DEPTH_BYTES
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] mem_address,
  output logic        mem_read_write,
  input  logic [31:0] mem_data_out,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  output logic        fault,
  output logic [31:0] fault_pc
);

  localparam logic [31:0] LAST_ADDR = STARTING_ADDR + MEM_DEPTH_BYTES - 32'd4;

  fetch_state_t state;
  logic [31:0]  pc;
  logic [1:0]   count;
  logic [63:0]  head_data;
  logic         legal;
  logic         deq;
  logic         space;
  logic         flush;
  logic         enq;

  assign legal = (pc[1:0] == 2'b00) && (pc >= STARTING_ADDR) && (pc <= LAST_ADDR);
  assign deq   = inst_valid & inst_ready;
  assign space = (count < 2'd2) | deq;

  // A redirect wins over everything, including a same-cycle decode handshake.
  assign flush = (state == RUN) & redirect_valid;
  assign enq   = (state == RUN) & ~redirect_valid & legal & space;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= RUN;
      pc       <= STARTING_ADDR;
      fault    <= 1'b0;
      fault_pc <= '0;
    end else begin
      case (state)
        RUN: begin
          if (redirect_valid) begin
            pc <= redirect_pc;
          end else if (!legal) begin
            state    <= FAULT;
            fault    <= 1'b1;
            fault_pc <= pc;
          end else if (space) begin
            pc <= pc + 32'd4;
          end
        end
        FAULT: ;
        default: state <= FAULT;
      endcase
    end
  end

  fetch_buffer #(.WIDTH(64)) u_buffer (
    .clock      (clock),
    .reset      (reset),
    .enq        (enq),
    .deq        (deq & ~flush),
    .flush      (flush),
    .enq_data   ({pc, mem_data_out}),
    .head_data  (head_data),
    .head_valid (inst_valid),
    .count      (count)
  );

  assign mem_address    = pc;
  assign mem_read_write = READ;
  assign inst_out       = head_data[31:0];
  assign inst_pc        = head_data[63:32];

endmodule
